// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output path.
package audio_pkg;

  localparam int SAMPLE_WIDTH      = 16;
  localparam int CLK_PER_HALF_SCLK = 16;
  localparam int BIT_IDX_W         = $clog2(2 * SAMPLE_WIDTH);
  localparam int SAMPLE_IDX_W      = $clog2(SAMPLE_WIDTH);

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic [BIT_IDX_W-1:0]    bit_idx_t;

  // Word bit carried in I2S bit period p. The one-bit delay puts the left MSB
  // in period 1, and the right LSB spills into period 0 of the next frame.
  function automatic logic [SAMPLE_IDX_W-1:0] tx_bit_sel(bit_idx_t p);
    if (p == '0)
      return '0;
    else if (int'(p) <= SAMPLE_WIDTH)
      return SAMPLE_IDX_W'(SAMPLE_WIDTH - int'(p));
    else
      return SAMPLE_IDX_W'(2 * SAMPLE_WIDTH - int'(p));
  endfunction

endpackage

// File: rtl/i2s_sample_tx_if.sv
// Sample input strobe from the effects pipeline plus the I2S/flag outputs.
interface i2s_sample_tx_if;
  import audio_pkg::*;

  logic    valid;
  sample_t sample_in;
  logic    sclk;
  logic    lrclk;
  logic    sdata;
  logic    underrun;
  logic    overrun;

  modport master (
    output valid, sample_in,
    input  sclk, lrclk, sdata, underrun, overrun
  );

  modport slave (
    input  valid, sample_in,
    output sclk, lrclk, sdata, underrun, overrun
  );
endinterface

// File: rtl/flipflop.sv
// Generic enabled register with synchronous active-high reset.
module flipflop #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d whenever enabled.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/i2s_clock_gen.sv
// SCLK divider and I2S bit-period counter. The counters hold the position of
// the cycle currently on the outputs; the strobes describe the cycle about to
// begin, so the top level can launch registered data exactly on the edge that
// starts each bit period.
module i2s_clock_gen
  import audio_pkg::*;
#(
  parameter int clk_per_half_sclk = CLK_PER_HALF_SCLK
) (
  input  logic     clk,
  input  logic     rst,
  output logic     sclk,
  output logic     lrclk,
  output bit_idx_t bit_idx,
  output logic     period_start,
  output logic     load
);

  localparam int HALF_W = $clog2(clk_per_half_sclk);
  localparam logic [HALF_W-1:0] HALF_LAST   = HALF_W'(clk_per_half_sclk - 1);
  localparam bit_idx_t          PERIOD_LAST = BIT_IDX_W'(2 * SAMPLE_WIDTH - 1);
  localparam bit_idx_t          FIRST_RIGHT = BIT_IDX_W'(SAMPLE_WIDTH);

  logic [HALF_W-1:0] half_cnt;
  logic [HALF_W-1:0] nxt_half;
  logic              nxt_high;
  bit_idx_t          period_q;
  bit_idx_t          nxt_period;
  logic              half_end;

  // Next divider position; a period ends at the end of its high half.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    half_end     = 1'b0;
    nxt_half     = '0;
    nxt_high     = sclk;
    nxt_period   = period_q;
    period_start = 1'b0;
    load         = 1'b0;

    half_end = (half_cnt == HALF_LAST);
    nxt_half = half_end ? '0 : half_cnt + 1'b1;
    if (half_end)
      nxt_high = ~sclk;
    if (half_end && sclk) begin
      period_start = 1'b1;
      nxt_period   = (period_q == PERIOD_LAST) ? '0 : period_q + 1'b1;
    end
    load = period_start && (nxt_period == BIT_IDX_W'(1));
  end

  assign bit_idx = nxt_period;

  // Advance the divider; sclk is the half-period phase register itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt <= '0;
      sclk     <= 1'b0;
      period_q <= '0;
      lrclk    <= 1'b0;
    end else begin
      half_cnt <= nxt_half;
      sclk     <= nxt_high;
      period_q <= nxt_period;
      lrclk    <= (nxt_period >= FIRST_RIGHT);
    end
  end

endmodule

// File: rtl/i2s_sample_tx.sv
// Mono I2S transmitter: one pending sample buffer decoupling the effects
// pipeline strobe from frame timing, with underrun/overrun pulses. The load
// decision is taken in the final cycle of period 0 so the new MSB is on sdata
// from the very first cycle of period 1; a valid strobe in that cycle is the
// one that collides with the load.
module i2s_sample_tx
  import audio_pkg::*;
#(
  parameter int clk_per_half_sclk = CLK_PER_HALF_SCLK
) (
  input  logic clk,
  input  logic rst,
  i2s_sample_tx_if.slave bus
);

  bit_idx_t bit_idx;
  logic     period_start;
  logic     load;
  sample_t  holding_q;
  sample_t  tx_q;
  sample_t  eff_sample;
  logic     pending_q;

  i2s_clock_gen #(
    .clk_per_half_sclk(clk_per_half_sclk)
  ) u_clock_gen (
    .clk          (clk),
    .rst          (rst),
    .sclk         (bus.sclk),
    .lrclk        (bus.lrclk),
    .bit_idx      (bit_idx),
    .period_start (period_start),
    .load         (load)
  );

  // A strobe always wins over the held value, on load cycles included.
  assign eff_sample = bus.valid ? bus.sample_in : holding_q;

  flipflop #(
    .WIDTH(SAMPLE_WIDTH)
  ) u_holding (
    .clk (clk),
    .rst (rst),
    .en  (bus.valid || load),
    .d   (eff_sample),
    .q   (holding_q)
  );

  // Pending flag, transmit word, serial data and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= 1'b0;
      tx_q         <= '0;
      bus.sdata    <= 1'b0;
      bus.underrun <= 1'b0;
      bus.overrun  <= 1'b0;
    end else begin
      bus.overrun  <= bus.valid && pending_q;
      bus.underrun <= load && !bus.valid && !pending_q;

      if (load) begin
        tx_q      <= eff_sample;
        pending_q <= 1'b0;
      end else if (bus.valid) begin
        pending_q <= 1'b1;
      end

      if (period_start)
        bus.sdata <= load ? eff_sample[SAMPLE_WIDTH-1] : tx_q[tx_bit_sel(bit_idx)];
    end
  end

endmodule
